// File: rtl/phasenoisepon_nibble_regfile_pkg.sv
// Shared command codes, FSM state type and address-width helper for the nibble register file.
package phasenoisepon_nib_pkg;
  localparam logic [1:0] CMD_LOAD_NIB = 2'b00;
  localparam logic [1:0] CMD_SET_ADDR = 2'b01;
  localparam logic [1:0] CMD_COMMIT   = 2'b10;
  localparam logic [1:0] CMD_READ     = 2'b11;
  localparam logic [3:0] CLR_ERR_CODE = 4'hF;

  typedef enum logic {ST_IDLE, ST_READ} state_e;

  typedef struct packed {
    logic [1:0] cmd;
    logic [3:0] din;
  } cmd_req_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/phasenoisepon_nibble_regfile_if.sv
// Command / readout bus of the nibble register file.
interface phasenoisepon_nibble_regfile_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [3:0] din;
  logic [3:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       full;
  logic       err;

  modport master (output cmd_valid, cmd, din,
                  input  dout, dout_valid, busy, full, err);
  modport slave  (input  cmd_valid, cmd, din,
                  output dout, dout_valid, busy, full, err);
endinterface

// File: rtl/phasenoisepon_nib_serializer.sv
// Parallel-load shifter emitting a word MS nibble first, one nibble per cycle.
module phasenoisepon_nib_serializer #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic [3:0]        dout,
  output logic              dout_valid,
  output logic              last
);
  localparam int NIBBLES = WORD_W / 4;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  logic [WORD_W-1:0] sh;
  logic [CNT_W-1:0]  rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      rem <= '0;
    end else if (load) begin
      sh  <= word;
      rem <= CNT_W'(NIBBLES);
    end else if (rem != '0) begin
      sh  <= sh << 4;
      rem <= rem - 1'b1;
    end
  end

  // Outputs come straight from flops, so reset clears them without a clock.
  assign dout_valid = (rem != '0);
  assign dout       = dout_valid ? sh[WORD_W-1 -: 4] : 4'h0;
  assign last       = (rem == CNT_W'(1));
endmodule

// File: rtl/phasenoisepon_nibble_regfile.sv
// Nibble-serial register file: staging loader, addressed word store, serial readout, sticky error.
module phasenoisepon_nibble_regfile
  import phasenoisepon_nib_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  phasenoisepon_nibble_regfile_if.slave  bus
);
  localparam int NIBBLES = WORD_W / 4;
  localparam int CNT_W   = $clog2(NIBBLES + 1);
  localparam int ADDR_W  = addr_w(NUM_WORDS);

  if (WORD_W < 4 || (WORD_W % 4) != 0) begin : g_bad_width
    $error("phasenoisepon_nibble_regfile: WORD_W must be a multiple of 4 and >= 4");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > 15) begin : g_bad_depth
    $error("phasenoisepon_nibble_regfile: NUM_WORDS must be 1..15");
  end

  state_e state, state_nxt;
  logic [NUM_WORDS-1:0][WORD_W-1:0] mem;
  logic [WORD_W-1:0] staging;
  logic [CNT_W-1:0]  nib_cnt;
  logic [ADDR_W-1:0] addr;
  logic              err_q;
  logic              full;
  logic              cmd_ok, drop, rd_load;
  logic              ser_valid, ser_last;
  logic [3:0]        ser_dout;
  cmd_req_t          req;

  assign req  = '{cmd: bus.cmd, din: bus.din};
  assign full = (nib_cnt == CNT_W'(NIBBLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rd_load)  state_nxt = ST_READ;
      ST_READ: if (ser_last) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ok  = 1'b0;
    drop    = 1'b0;
    rd_load = 1'b0;
    if (bus.cmd_valid) begin
      if (state == ST_IDLE) cmd_ok = 1'b1;
      else                  drop   = 1'b1;
    end
    rd_load = cmd_ok && (req.cmd == CMD_READ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem     <= '0;
      staging <= '0;
      nib_cnt <= '0;
      addr    <= '0;
      err_q   <= 1'b0;
    end else if (drop) begin
      err_q <= 1'b1;
    end else if (cmd_ok) begin
      case (req.cmd)
        CMD_LOAD_NIB:
          if (!full) begin
            staging <= (staging << 4) | WORD_W'(req.din);
            nib_cnt <= nib_cnt + 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        CMD_SET_ADDR:
          if (req.din == CLR_ERR_CODE) begin
            err_q   <= 1'b0;
            nib_cnt <= '0;
          end else if ({28'd0, req.din} < 32'(NUM_WORDS)) begin
            addr <= req.din[ADDR_W-1:0];
          end else begin
            err_q <= 1'b1;
          end
        CMD_COMMIT:
          if (full) begin
            mem[addr] <= staging;
            nib_cnt   <= '0;
            addr      <= (addr == ADDR_W'(NUM_WORDS - 1)) ? '0 : addr + 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        default: ;  // READ only starts the serializer
      endcase
    end
  end

  phasenoisepon_nib_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .load       (rd_load),
    .word       (mem[addr]),
    .dout       (ser_dout),
    .dout_valid (ser_valid),
    .last       (ser_last)
  );

  assign bus.dout       = ser_dout;
  assign bus.dout_valid = ser_valid;
  assign bus.busy       = (state == ST_READ);
  assign bus.full       = full;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_phasenoisepon_nibble_regfile.sv
// Randomized and directed bench for the nibble register file against a word-level reference model.
module tb_phasenoisepon_nibble_regfile;
  localparam int WW  = 16;
  localparam int NW  = 4;
  localparam int NIB = WW / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phasenoisepon_nibble_regfile_if bus();

  phasenoisepon_nibble_regfile #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [WW-1:0] m_mem [NW];
  logic [WW-1:0] m_stg;
  int            m_cnt, m_addr;
  bit            m_err;
  logic [3:0]    q[$];

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) m_mem[i] = '0;
    m_stg = '0; m_cnt = 0; m_addr = 0; m_err = 0;
    q.delete();
  endfunction

  function automatic void model_edge(bit v, logic [1:0] c, logic [3:0] d);
    bit was_busy;
    was_busy = (q.size() > 0);
    if (was_busy) void'(q.pop_front());
    if (!v) return;
    if (was_busy) begin m_err = 1; return; end
    case (c)
      2'b00: if (m_cnt < NIB) begin m_stg = {m_stg[WW-5:0], d}; m_cnt++; end
             else m_err = 1;
      2'b01: if (d == 4'hF) begin m_err = 0; m_cnt = 0; end
             else if (int'(d) < NW) m_addr = int'(d);
             else m_err = 1;
      2'b10: if (m_cnt == NIB) begin
               m_mem[m_addr] = m_stg; m_cnt = 0; m_addr = (m_addr + 1) % NW;
             end else m_err = 1;
      default: for (int i = NIB - 1; i >= 0; i--) q.push_back(m_mem[m_addr][i*4 +: 4]);
    endcase
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus.dout_valid, bus.dout, bus.busy, bus.full, bus.err};
  endfunction

  function automatic logic [7:0] exp_vec();
    bit v;
    v = (q.size() > 0);
    return {v, v ? q[0] : 4'h0, v, (m_cnt == NIB), m_err};
  endfunction

  // one clock: drive a command (or idle), advance model, land 1 time unit past the edge
  task automatic tick(bit v, logic [1:0] c, logic [3:0] d);
    @(negedge clk);
    bus.cmd_valid = v; bus.cmd = c; bus.din = d;
    @(posedge clk);
    model_edge(v, c, d);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] o, e;
    bus.cmd_valid = 0; bus.cmd = 0; bus.din = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    o = obs_vec(); e = 8'h00;
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL reset_outputs got=%h want=%h", o, e); end
    @(negedge clk) rst_n = 1;
    for (int a = 0; a < NW; a++) begin
      tick(1, 2'b01, 4'(a));
      tick(1, 2'b11, 4'h0);
      repeat (NIB + 1) begin
        tick(0, 2'b00, 4'h0);
        o = obs_vec(); e = exp_vec(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_mem%0d got=%h want=%h", a, o, e); end
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] o, e;
    logic [3:0] seq_c[8] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b11};
    logic [3:0] seq_d[8] = '{4'h0, 4'hA, 4'hB, 4'hC, 4'hD, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 8; i++) begin
      tick(1, seq_c[i][1:0], seq_d[i]);
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL basic_cmd%0d got=%h want=%h", i, o, e); end
    end
    for (int i = 0; i < NIB + 1; i++) begin
      tick(0, 2'b00, 4'h0);
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL basic_read%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_errors();
    logic [7:0] o, e;
    logic [1:0] sc[12] = '{0, 0, 0, 2, 0, 0, 1, 1, 3, 0, 0, 0};
    logic [3:0] sd[12] = '{1, 2, 3, 0, 4, 5, 4'hF, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      tick(i < 9, sc[i], sd[i]);
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL errors_step%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_addr();
    logic [7:0] o, e;
    logic [1:0] sc[14] = '{1, 1, 0, 0, 0, 0, 2, 1, 1, 3, 0, 0, 0, 0};
    logic [3:0] sd[14] = '{1, 4, 1, 1, 1, 1, 0, 4'hF, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      tick(i < 10, sc[i], sd[i]);
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL addr_step%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] o, e;
    tick(1, 2'b01, 4'd3);
    for (int k = 0; k < NW; k++) begin
      for (int n = NIB - 1; n >= 0; n--) tick(1, 2'b00, (n == 0) ? 4'((k + 3) % NW) : 4'h0);
      tick(1, 2'b10, 4'h0);
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wrap_commit%0d got=%h want=%h", k, o, e); end
    end
    for (int a = 0; a < NW; a++) begin
      tick(1, 2'b01, 4'(a));
      tick(1, 2'b11, 4'h0);
      repeat (NIB) begin
        tick(0, 2'b00, 4'h0);
        o = obs_vec(); e = exp_vec(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL wrap_read%0d got=%h want=%h", a, o, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] o, e;
    // READ, then LOAD 7 on readout cycles 2 and 4 (dropped) and right after (accepted)
    bit v[7] = '{1, 0, 1, 0, 1, 1, 0};
    tick(1, 2'b01, 4'hF);
    for (int i = 0; i < 7; i++) begin
      tick(v[i], (i == 0) ? 2'b11 : 2'b00, (i == 0) ? 4'h0 : 4'h7);
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_step%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] o, e;
    tick(1, 2'b11, 4'h0);
    tick(0, 2'b00, 4'h0);
    #2 rst_n = 0;
    #1;
    model_reset();
    o = obs_vec(); e = 8'h00; n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL async_reset got=%h want=%h", o, e); end
    @(negedge clk) rst_n = 1;
    tick(1, 2'b11, 4'h0);
    repeat (NIB + 1) begin
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL async_read got=%h want=%h", o, e); end
      tick(0, 2'b00, 4'h0);
    end
  endtask

  task automatic test_random();
    logic [7:0] o, e;
    logic [1:0] c;
    logic [3:0] d;
    bit v;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = 2'($urandom_range(0, 3));
      if (c == 2'b00 && $urandom_range(0, 1) == 1) c = 2'b10;
      d = 4'($urandom);
      if (c == 2'b01) d = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, NW));
      tick(v, c, d);
      o = obs_vec(); e = exp_vec(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL random_cyc%0d got=%h want=%h", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_addr();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
